// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared widths and state encoding for the sparse-map decode scheduler
package sm_pkg;

    localparam int SM_W   = 16;
    localparam int HAMW_W = 4;
    localparam int IDX_W  = 9;
    localparam int TMO_W  = 10;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_ISSUE = 4'd2;
    localparam logic [3:0] ST_ACK   = 4'd3;
    localparam logic [3:0] ST_RUN   = 4'd4;
    localparam logic [3:0] ST_ADV   = 4'd5;
    localparam logic [3:0] ST_DONE  = 4'd6;
    localparam logic [3:0] ST_ERR   = 4'd7;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_ISSUE = ST_ISSUE,
        S_ACK   = ST_ACK,
        S_RUN   = ST_RUN,
        S_ADV   = ST_ADV,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_t;

endpackage

// File: rtl/sm_seg_idx_counter.sv
// rtl/sm_seg_idx_counter.sv - segment row/col index counter with last-segment flag
module sm_seg_idx_counter
    import sm_pkg::*;
#(
    parameter int SEG_PER_ROW = 16,
    parameter int ROWS        = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(SEG_PER_ROW - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            // Row keeps counting past the last row; the next frame clears it.
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/sm_decode_sched.sv
// rtl/sm_decode_sched.sv - frame scheduler feeding the SM decoder; optional SM_SKIP_EMPTY_EN
module sm_decode_sched
    import sm_pkg::*;
#(
    parameter int SEG_PER_ROW = 16,
    parameter int ROWS        = 240,
    parameter int TMO_CYC     = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_abort,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              err_tmo,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [SM_W-1:0]   desc_sm,
    input  logic [HAMW_W-1:0] desc_hamw,
    output logic              dec_start,
    output logic [SM_W-1:0]   dec_sm,
    output logic [HAMW_W-1:0] dec_hamw,
    input  logic              dec_busy,
    output logic [IDX_W-1:0]  seg_row,
    output logic [IDX_W-1:0]  seg_col
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              idx_clr, idx_step, idx_last;
    logic              latch, tmo_clr, tmo_inc, err_set;

    sm_seg_idx_counter #(
        .SEG_PER_ROW (SEG_PER_ROW),
        .ROWS        (ROWS)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .step (idx_step),
        .row  (seg_row),
        .col  (seg_col),
        .last (idx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            dec_sm   <= '0;
            dec_hamw <= '0;
            err_tmo  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tmo_clr)
                tmo_q <= '0;
            else if (tmo_inc && (tmo_q != '1))
                tmo_q <= tmo_q + 1'b1;
            if (latch) begin
                dec_sm   <= desc_sm;
                dec_hamw <= desc_hamw;
            end
            if (idx_clr)
                err_tmo <= 1'b0;
            else if (err_set)
                err_tmo <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        desc_ready = 1'b0;
        dec_start  = 1'b0;
        frame_done = 1'b0;
        idx_clr    = 1'b0;
        idx_step   = 1'b0;
        latch      = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    idx_clr = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    latch   = 1'b1;
                    state_d = S_ISSUE;
`ifdef SM_SKIP_EMPTY_EN
                    if (desc_sm == '0)
                        state_d = S_ADV;
`endif
                end
            end
            S_ISSUE: begin
                dec_start = 1'b1;
                tmo_clr   = 1'b1;
                state_d   = S_ACK;
            end
            S_ACK: begin
                tmo_inc = 1'b1;
                if (dec_busy) begin
                    state_d = S_RUN;
                end else if (tmo_q == TMO_LIM) begin
                    err_set = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_RUN: begin
                tmo_inc = 1'b1;
                if (!dec_busy) begin
                    state_d = S_ADV;
                end else if (tmo_q == TMO_LIM) begin
                    err_set = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ADV: begin
                idx_step = 1'b1;
                state_d  = idx_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over everything: drop any same-cycle descriptor and never start the decoder.
        if (frame_abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            dec_start = 1'b0;
            idx_step  = 1'b0;
            latch     = 1'b0;
            err_set   = 1'b0;
        end
    end

    assign frame_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm_decode_sched.sv
// tb/tb_sm_decode_sched.sv - directed self-checking bench for sm_decode_sched
module tb_sm_decode_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, frame_abort;
    logic        frame_busy, frame_done, err_tmo;
    logic        desc_valid, desc_ready;
    logic [15:0] desc_sm;
    logic [3:0]  desc_hamw;
    logic        dec_start;
    logic [15:0] dec_sm;
    logic [3:0]  dec_hamw;
    logic        dec_busy;
    logic [8:0]  seg_row, seg_col;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_done  = 0;
    int n_hs    = 0;

    always #5 clk = ~clk;

    sm_decode_sched #(
        .SEG_PER_ROW (2),
        .ROWS        (2),
        .TMO_CYC     (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_abort (frame_abort),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .err_tmo     (err_tmo),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_sm     (desc_sm),
        .desc_hamw   (desc_hamw),
        .dec_start   (dec_start),
        .dec_sm      (dec_sm),
        .dec_hamw    (dec_hamw),
        .dec_busy    (dec_busy),
        .seg_row     (seg_row),
        .seg_col     (seg_col)
    );

    always @(posedge clk) begin
        if (dec_start === 1'b1) n_start++;
        if (frame_done === 1'b1) n_done++;
        if ((desc_valid && desc_ready) === 1'b1) n_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From FETCH: hand over one descriptor and bring the decoder into RUN.
    task automatic go_run(input logic [15:0] sm, input logic [3:0] hw);
        desc_valid = 1'b1;
        desc_sm    = sm;
        desc_hamw  = hw;
        tick();
        desc_valid = 1'b0;
        chk("issue_start", dec_start, 1);
        chk("issue_sm", dec_sm, sm);
        chk("issue_hamw", dec_hamw, hw);
        tick();
        chk("ack_nostart", dec_start, 0);
        dec_busy = 1'b1;
        tick();
    endtask

    task automatic run_seg(input logic [15:0] sm, input logic [3:0] hw, input int busy_cyc,
                           input int row, input int col);
        chk("fetch_ready", desc_ready, 1);
        chk("seg_row", seg_row, row);
        chk("seg_col", seg_col, col);
        go_run(sm, hw);
        repeat (busy_cyc - 1) tick();
        dec_busy = 1'b0;
        tick();
        chk("run_busy", frame_busy, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0;
        desc_valid = 1'b0; desc_sm = '0; desc_hamw = '0; dec_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err_tmo, 0);
        chk("rst_ready", desc_ready, 0);
        chk("rst_start", dec_start, 0);
        chk("rst_sm", dec_sm, 0);
        chk("rst_hamw", dec_hamw, 0);
        chk("rst_row", seg_row, 0);
        chk("rst_col", seg_col, 0);

        // T1: full 2x2 frame, 3-cycle decoder; a frame_start mid-frame must be ignored
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("t1_busy", frame_busy, 1);
        run_seg(16'h8001, 4'd2, 3, 0, 0);
        run_seg(16'hF00F, 4'd8, 3, 0, 1);
        frame_start = 1'b1;
        run_seg(16'hFFFF, 4'd0, 3, 1, 0);
        frame_start = 1'b0;
        run_seg(16'h0F0F, 4'd8, 3, 1, 1);
        chk("t1_done_pulse", frame_done, 1);
        tick();
        chk("t1_done_low", frame_done, 0);
        chk("t1_idle", frame_busy, 0);
        chk("t1_starts", n_start, 4);
        chk("t1_dones", n_done, 1);
        chk("t1_desc", n_hs, 4);
        chk("t1_err", err_tmo, 0);
        chk("t1_end_row", seg_row, 2);
        chk("t1_end_col", seg_col, 0);

        // T2: starved FETCH, then T5a: abort on the same cycle as a handshake
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("t2_row_clr", seg_row, 0);
        for (int i = 0; i < 20; i++) begin
            frame_start = (i == 5);
            chk("t2_ready", desc_ready, 1);
            chk("t2_nostart", dec_start, 0);
            tick();
        end
        frame_start = 1'b0;
        chk("t2_starts", n_start, 4);
        chk("t2_col", seg_col, 0);
        desc_valid = 1'b1; desc_sm = 16'h1234; desc_hamw = 4'd5; frame_abort = 1'b1;
        tick();
        desc_valid = 1'b0; frame_abort = 1'b0;
        chk("t5a_idle", frame_busy, 0);
        chk("t5a_nostart", dec_start, 0);
        chk("t5a_drop_sm", dec_sm, 16'h0F0F);
        repeat (3) tick();
        chk("t5a_starts", n_start, 4);
        chk("t5a_dones", n_done, 1);

        // T5b: abort while the decoder runs
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        go_run(16'h00FF, 4'd8);
        chk("t5b_inrun", frame_busy, 1);
        frame_abort = 1'b1; tick(); frame_abort = 1'b0;
        dec_busy = 1'b0;
        chk("t5b_idle", frame_busy, 0);
        repeat (10) tick();
        chk("t5b_starts", n_start, 5);
        chk("t5b_dones", n_done, 1);

        // T3: decoder never rises; 16 ACK cycles then ERR
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        desc_valid = 1'b1; desc_sm = 16'h0100; desc_hamw = 4'd1;
        tick();
        desc_valid = 1'b0;
        chk("t3_start", dec_start, 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t3_no_err_yet", err_tmo, 0);
            tick();
        end
        chk("t3_err", err_tmo, 1);
        repeat (4) tick();
        chk("t3_err_busy", frame_busy, 1);
        frame_abort = 1'b1; tick(); frame_abort = 1'b0;
        chk("t3_abort_idle", frame_busy, 0);
        repeat (3) tick();
        chk("t3_err_sticky", err_tmo, 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("t3_err_clr", err_tmo, 0);

        // T4: empty sparse map
        desc_valid = 1'b1; desc_sm = 16'h0000; desc_hamw = 4'd0;
        tick();
        desc_valid = 1'b0;
`ifdef SM_SKIP_EMPTY_EN
        chk("t4_skip_nostart", dec_start, 0);
        tick();
        chk("t4_skip_col", seg_col, 1);
        chk("t4_skip_ready", desc_ready, 1);
        chk("t4_skip_starts", n_start, 6);
`else
        chk("t4_dispatch", dec_start, 1);
        repeat (20) tick();
        chk("t4_tmo_err", err_tmo, 1);
        chk("t4_starts", n_start, 7);
`endif
        frame_abort = 1'b1; tick(); frame_abort = 1'b0;
        chk("t4_idle", frame_busy, 0);

        // T6: reset in the middle of the second segment's RUN
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        run_seg(16'h0001, 4'd1, 1, 0, 0);
        go_run(16'hAAAA, 4'd8);
        chk("t6_col_pre", seg_col, 1);
        rst = 1'b1; tick(); rst = 1'b0; dec_busy = 1'b0;
        chk("t6_busy", frame_busy, 0);
        chk("t6_err", err_tmo, 0);
        chk("t6_sm", dec_sm, 0);
        chk("t6_hamw", dec_hamw, 0);
        chk("t6_col", seg_col, 0);
        chk("t6_ready", desc_ready, 0);
        repeat (3) tick();
        chk("t6_no_done", frame_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
